// File: rtl/mmm_ctrl_if.sv
// Handshake/strobe bundle between the RSA controller, mmm_ctrl and its mmm_unit.
// Optional irq/irq_clr signals exist only when MMM_CTRL_IRQ_EN is defined.
interface mmm_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic             abort;
    logic             hold;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic             clear;
    logic             ld_a;
    logic             ena;
    logic             ld_r;
    logic             lock;
    logic [CNT_W-1:0] iter;
`ifdef MMM_CTRL_IRQ_EN
    logic             irq_clr;
    logic             irq;

    modport master (
        output start, abort, hold, irq_clr,
        input  busy, done, result_valid, clear, ld_a, ena, ld_r, lock, iter, irq
    );

    modport slave (
        input  start, abort, hold, irq_clr,
        output busy, done, result_valid, clear, ld_a, ena, ld_r, lock, iter, irq
    );
`else
    modport master (
        output start, abort, hold,
        input  busy, done, result_valid, clear, ld_a, ena, ld_r, lock, iter
    );

    modport slave (
        input  start, abort, hold,
        output busy, done, result_valid, clear, ld_a, ena, ld_r, lock, iter
    );
`endif

endinterface

// File: rtl/mmm_ctrl.sv
// Sequencer for one mmm_unit: CLEAR, LOAD, WIDTH RUN iterations, STORE, DONE.
// Define MMM_CTRL_IRQ_EN to add a sticky completion interrupt (irq / irq_clr).
module mmm_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rstb,
    mmm_ctrl_if.slave   m
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_STORE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic clear;
        logic ld_a;
        logic ena;
        logic run;
        logic ld_r;
        logic lock;
    } strb_t;

    state_t           state;
    strb_t            strb;
    logic [CNT_W-1:0] iter_r;
    logic             rv_r;

    // Strobe pattern for the cycle spent in state s; registered on the entering edge.
    function automatic strb_t outs(state_t s, logic rv);
        strb_t o;
        o       = '0;
        o.busy  = (s != S_IDLE);
        o.done  = (s == S_DONE);
        o.clear = (s == S_CLEAR);
        o.ld_a  = (s == S_LOAD);
        o.run   = (s == S_RUN);
        o.ld_r  = (s == S_STORE);
        o.ena   = (s == S_CLEAR) || (s == S_LOAD) || (s == S_RUN) || (s == S_STORE);
        o.lock  = (s == S_DONE) || ((s == S_IDLE) && rv);
        return o;
    endfunction

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state  <= S_IDLE;
            strb   <= '0;
            iter_r <= '0;
            rv_r   <= 1'b0;
        end else if (m.abort) begin
            state  <= S_IDLE;
            strb   <= outs(S_IDLE, 1'b0);
            iter_r <= '0;
            rv_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (m.start) begin
                        state <= S_CLEAR;
                        strb  <= outs(S_CLEAR, 1'b0);
                        rv_r  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state <= S_LOAD;
                    strb  <= outs(S_LOAD, 1'b0);
                end
                S_LOAD: begin
                    state  <= S_RUN;
                    strb   <= outs(S_RUN, 1'b0);
                    iter_r <= '0;
                end
                S_RUN: begin
                    // Hold freezes both the counter and the state; strobes stay as-is.
                    if (!m.hold) begin
                        if (iter_r == LAST_ITER) begin
                            state  <= S_STORE;
                            strb   <= outs(S_STORE, 1'b0);
                            iter_r <= '0;
                        end else begin
                            iter_r <= iter_r + CNT_W'(1);
                        end
                    end
                end
                S_STORE: begin
                    state <= S_DONE;
                    strb  <= outs(S_DONE, 1'b1);
                    rv_r  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    strb  <= outs(S_IDLE, rv_r);
                end
                default: begin
                    state  <= S_IDLE;
                    strb   <= '0;
                    iter_r <= '0;
                    rv_r   <= 1'b0;
                end
            endcase
        end
    end

    assign m.busy         = strb.busy;
    assign m.done         = strb.done;
    assign m.result_valid = rv_r;
    assign m.clear        = strb.clear;
    assign m.ld_a         = strb.ld_a;
    assign m.ld_r         = strb.ld_r;
    assign m.lock         = strb.lock;
    assign m.iter         = iter_r;
    // Only hold may reach a strobe combinationally, and only ena during RUN.
    assign m.ena          = strb.ena & ~(strb.run & m.hold);

`ifdef MMM_CTRL_IRQ_EN
    logic irq_r;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            irq_r <= 1'b0;
        end else if ((state == S_DONE) && !m.abort) begin
            irq_r <= 1'b1;
        end else if (m.irq_clr) begin
            irq_r <= 1'b0;
        end
    end

    assign m.irq = irq_r;
`endif

endmodule

// File: tb/tb_mmm_ctrl.sv
// Self-checking bench for mmm_ctrl: per-cycle expected output words from the
// operation timeline are queued as stimulus is driven and compared as the DUT responds.
module tb_mmm_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int OW    = 8 + CNT_W;

    logic clk = 1'b0;
    logic rstb;

    always #5 clk = ~clk;

    mmm_ctrl_if #(.WIDTH(WIDTH)) m ();

    mmm_ctrl #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rstb (rstb),
        .m    (m)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [OW-1:0] exp_q[$];

    function automatic logic [OW-1:0] mk(logic busy, logic done, logic rv, logic clr,
                                         logic lda, logic ena, logic ldr, logic lock, int it);
        logic [CNT_W-1:0] i;
        i = CNT_W'(it);
        return {busy, done, rv, clr, lda, ena, ldr, lock, i};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {m.busy, m.done, m.result_valid, m.clear, m.ld_a, m.ena, m.ld_r, m.lock, m.iter};
    endfunction

    // Expected outputs c cycles after start is sampled (c=1 is CLEAR), with hold
    // asserted during cycles hs..hs+hl-1 of RUN; rv0 is result_valid before the start.
    function automatic logic [OW-1:0] op_word(int c, int hs, int hl, logic rv0);
        int last_run;
        int held_before;
        logic held_now;
        last_run    = WIDTH + 2 + hl;
        held_before = 0;
        for (int j = hs; j < hs + hl; j++)
            if (j < c) held_before++;
        held_now = (hl > 0) && (c >= hs) && (c < hs + hl);
        if (c <= 0)             return mk(0, 0, rv0, 0, 0, 0, 0, rv0, 0);
        if (c == 1)             return mk(1, 0, 0, 1, 0, 1, 0, 0, 0);
        if (c == 2)             return mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
        if (c <= last_run)      return mk(1, 0, 0, 0, 0, !held_now, 0, 0, (c - 3) - held_before);
        if (c == last_run + 1)  return mk(1, 0, 0, 0, 0, 1, 1, 0, 0);
        if (c == last_run + 2)  return mk(1, 1, 1, 0, 0, 0, 0, 1, 0);
        return mk(0, 0, 1, 0, 0, 0, 0, 1, 0);
    endfunction

    task automatic step(input logic st, input logic ab, input logic ho);
        @(posedge clk);
        #1;
        m.start = st;
        m.abort = ab;
        m.hold  = ho;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [OW-1:0] got;
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", got, {OW{1'b0}});
        end
        m.start = 1'b1;
        @(negedge clk);
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_start_ignored: got %h want %h", got, {OW{1'b0}});
        end
        m.start = 1'b0;
        rstb    = 1'b0;
        @(negedge clk);
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %h want %h", got, {OW{1'b0}});
        end
    endtask

    task automatic test_single();
        logic [OW-1:0] got, e;
        int ena_cnt = 0;
        int done_cnt = 0;
        for (int c = 0; c <= 11; c++) begin
            exp_q.push_back(op_word(c, 0, 0, 1'b0));
            step(c == 0, 1'b0, 1'b0);
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL single cycle %0d: got %h want %h", c, got, e);
            end
            ena_cnt  += int'(m.ena);
            done_cnt += int'(m.done);
        end
        vectors++;
        if (ena_cnt !== 7 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL single_counts: got ena=%0d done=%0d want ena=7 done=1", ena_cnt, done_cnt);
        end
    endtask

    task automatic test_hold();
        logic [OW-1:0] got, e;
        int ena_cnt = 0;
        int done_cyc = -1;
        for (int c = 0; c <= 13; c++) begin
            exp_q.push_back(op_word(c, 4, 2, 1'b1));
            step(c == 0, 1'b0, (c >= 4) && (c < 6));
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got %h want %h", c, got, e);
            end
            ena_cnt += int'(m.ena);
            if (m.done) done_cyc = c;
        end
        m.hold = 1'b0;
        vectors++;
        if (ena_cnt !== 7 || done_cyc !== 10) begin
            miscompares++;
            $display("FAIL hold_counts: got ena=%0d done_cycle=%0d want ena=7 done_cycle=10", ena_cnt, done_cyc);
        end
    endtask

    task automatic test_abort();
        logic [OW-1:0] got, e;
        int done_cnt = 0;
        int done_cyc = -1;
        for (int c = 0; c <= 12; c++) begin
            exp_q.push_back((c <= 5) ? op_word(c, 0, 0, 1'b1) : mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            step(c == 0, c == 5, 1'b0);
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL abort cycle %0d: got %h want %h", c, got, e);
            end
            done_cnt += int'(m.done);
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt);
        end
        for (int c = 0; c <= 10; c++) begin
            exp_q.push_back(op_word(c, 0, 0, 1'b0));
            step(c == 0, 1'b0, 1'b0);
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL restart cycle %0d: got %h want %h", c, got, e);
            end
            if (m.done) done_cyc = c;
        end
        vectors++;
        if (done_cyc !== 8) begin
            miscompares++;
            $display("FAIL restart_done_cycle: got %0d want 8", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] got, e;
        int done_cnt = 0;
        for (int c = 0; c <= 22; c++) begin
            if (c < 9)        e = op_word(c, 0, 0, 1'b1);
            else if (c <= 18) e = op_word(c - 9, 0, 0, 1'b1);
            else if (c == 19) e = mk(0, 0, 1, 0, 0, 0, 0, 1, 0);
            else              e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
            exp_q.push_back(e);
            step((c <= 17) || (c == 19), c == 19, 1'b0);
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", c, got, e);
            end
            done_cnt += int'(m.done);
        end
        vectors++;
        if (done_cnt !== 2) begin
            miscompares++;
            $display("FAIL back_to_back_done_count: got %0d want 2", done_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [OW-1:0] got, e;
        for (int c = 0; c <= 4; c++) begin
            exp_q.push_back(op_word(c, 0, 0, 1'b0));
            step(c == 0, 1'b0, 1'b0);
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL pre_reset cycle %0d: got %h want %h", c, got, e);
            end
        end
        #2;
        rstb = 1'b1;
        #1;
        got = obs();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %h want %h", got, {OW{1'b0}});
        end
        @(negedge clk);
        rstb = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            exp_q.push_back(op_word(c, 0, 0, 1'b0));
            step(c == 0, 1'b0, 1'b0);
            got = obs();
            e   = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL post_reset cycle %0d: got %h want %h", c, got, e);
            end
        end
    endtask

`ifdef MMM_CTRL_IRQ_EN
    task automatic test_irq();
        logic exp_irq;
        logic exp_bq[$];
        for (int c = 0; c <= 12; c++) begin
            exp_bq.push_back((c >= 9) && (c <= 11));
            step(c == 0, 1'b0, 1'b0);
            m.irq_clr = (c == 11);
            exp_irq   = exp_bq.pop_front();
            vectors++;
            if (m.irq !== exp_irq) begin
                miscompares++;
                $display("FAIL irq cycle %0d: got %b want %b", c, m.irq, exp_irq);
            end
        end
        for (int c = 0; c <= 10; c++) begin
            exp_bq.push_back(c >= 9);
            step(c == 0, 1'b0, 1'b0);
            m.irq_clr = (c <= 8);
            exp_irq   = exp_bq.pop_front();
            vectors++;
            if (m.irq !== exp_irq) begin
                miscompares++;
                $display("FAIL irq_set_wins cycle %0d: got %b want %b", c, m.irq, exp_irq);
            end
        end
        m.irq_clr = 1'b0;
    endtask
`endif

    initial begin
        m.start = 1'b0;
        m.abort = 1'b0;
        m.hold  = 1'b0;
`ifdef MMM_CTRL_IRQ_EN
        m.irq_clr = 1'b0;
`endif
        rstb = 1'b1;
        test_reset();
        test_single();
        test_hold();
        test_abort();
        test_back_to_back();
        test_async_reset();
`ifdef MMM_CTRL_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
